// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD subtractor datapath.
package bcd_pkg;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned NDIGITS_DEFAULT = 14;
  localparam int unsigned BCD_RADIX       = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } bcd_state_t;

  // Folds a raw (DIGIT_W+1)-bit two's-complement digit difference back into 0..9.
  function automatic logic [DIGIT_W-1:0] bcd_fold(input logic [DIGIT_W:0] diff);
    logic [DIGIT_W:0] adj;
    adj = diff + (DIGIT_W+1)'(BCD_RADIX);
    return diff[DIGIT_W] ? adj[DIGIT_W-1:0] : diff[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single BCD digit subtract: d = a - b - bin, with borrow out.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W:0] diff;

  // Range of a - b - bin fits in DIGIT_W+1 bits, so the top bit is the sign.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
    bout = diff[DIGIT_W];
    d    = bcd_fold(diff);
  end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor Mr = M1 - M2, LSD first, start/done handshake.
// Optional BCD_SUB_MAGNITUDE_EN: negative results are re-negated to sign-magnitude.
module bcd_subtractor_serial
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = NDIGITS_DEFAULT
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIGIT_W*NDIGITS-1:0] M1,
  input  logic [DIGIT_W*NDIGITS-1:0] M2,
  output logic [DIGIT_W*NDIGITS-1:0] Mr,
  output logic                       neg,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned W     = DIGIT_W * NDIGITS;
  localparam int unsigned CNT_W = $clog2(NDIGITS + 1);

  bcd_state_t       state_q, state_d;
  logic [W-1:0]     m1_q, m1_d;
  logic [W-1:0]     m2_q, m2_d;
  logic [W-1:0]     mr_q, mr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             neg_q, neg_d;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_d;
  logic               dig_bout;

  bcd_digit_sub u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .bin  (br_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  // The NEG pass reuses the same digit slice with a zero minuend and Mr as subtrahend.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        if (state_q == NEG) begin
          dig_b = mr_q[i*DIGIT_W +: DIGIT_W];
        end else begin
          dig_a = m1_q[i*DIGIT_W +: DIGIT_W];
          dig_b = m2_q[i*DIGIT_W +: DIGIT_W];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    mr_d    = mr_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SUB;
          m1_d    = M1;
          m2_d    = M2;
          mr_d    = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          neg_d   = 1'b0;
        end
      end
      SUB: begin
        // One extra cycle at cnt == NDIGITS settles the sign before leaving SUB.
        if (cnt_q == CNT_W'(NDIGITS)) begin
          neg_d = br_q;
`ifdef BCD_SUB_MAGNITUDE_EN
          if (br_q) begin
            state_d = NEG;
            cnt_d   = '0;
            br_d    = 1'b0;
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end else begin
          for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) mr_d[i*DIGIT_W +: DIGIT_W] = dig_d;
          end
          br_d  = dig_bout;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef BCD_SUB_MAGNITUDE_EN
      NEG: begin
        for (int unsigned i = 0; i < NDIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) mr_d[i*DIGIT_W +: DIGIT_W] = dig_d;
        end
        br_d = dig_bout;
        if (cnt_q == CNT_W'(NDIGITS - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m1_q    <= '0;
      m2_q    <= '0;
      mr_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    Mr   = mr_q;
    neg  = neg_q;
    busy = (state_q == SUB) || (state_q == NEG);
    done = (state_q == DONE);
  end

endmodule
